writeback_trap: RTL and testbench

- Parametrised successor to the single-width writeback stage.
- Selects and registers the register-file and CSR write data.
- Prioritises exceptions and interrupts into an mcause-format code.
- Runs a trap-sequencing FSM that raises a context-switch pulse, suppresses the trapping instruction's writes and flushes the pipeline for a programmable number of cycles.
- Sits after the memory stage and feeds the register file, CSR file and fetch redirect.

---
 rtl/writeback_trap.sv | 279 +++++++++++++++++++++++++++
 tb/tb_writeback_trap.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_trap.sv
// writeback_trap: writeback stage with trap prioritisation and trap/flush sequencing.
// It selects and registers the register-file and CSR write data and encodes the
// highest-priority interrupt or exception into an mcause-format value. On a trap it
// pulses WB_CS, latches mcause/mepc/mtval and holds WB_FLUSH high for FLUSH_CYCLES
// cycles.
// Optional feature: define WB_RETIRE_CNT_EN to add the 64-bit WB_INSTRET retire counter.

module writeback_trap #(
  parameter int unsigned XLEN          = 64,
  parameter int unsigned ILEN          = 32,
  parameter int unsigned NUM_LOCAL_IRQ = 4,
  parameter int unsigned FLUSH_CYCLES  = 3
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     WB_V,
  input  logic [XLEN-1:0]          WB_PC,
  input  logic [XLEN-1:0]          WB_NPC,
  input  logic [ILEN-1:0]          WB_IR,
  input  logic [XLEN-1:0]          WB_ALU_RESULT,
  input  logic [XLEN-1:0]          WB_MEM_RESULT,
  input  logic [XLEN-1:0]          WB_RFD,
  input  logic [XLEN-1:0]          WB_CSRFD,
  input  logic [4:0]               WB_DRID,
  input  logic                     WB_PC_MUX,
  input  logic                     WB_ECALL,
  input  logic                     FE_IAM,
  input  logic                     FE_IAF,
  input  logic                     FE_II,
  input  logic                     MEM_LAM,
  input  logic                     MEM_LAF,
  input  logic                     MEM_SAM,
  input  logic                     MEM_SAF,
  input  logic [XLEN-1:0]          WB_BADADDR,
  input  logic                     TIMER,
  input  logic                     EXTERNAL,
  input  logic [NUM_LOCAL_IRQ-1:0] LOCAL_IRQ,
  input  logic                     GLOBAL_IE,
  input  logic                     PRIVILEGE,
  output logic [XLEN-1:0]          WB_RF_DATA,
  output logic [4:0]               WB_DRID_OUT,
  output logic                     WB_ST_REG,
  output logic [XLEN-1:0]          WB_CSR_DATA,
  output logic                     WB_ST_CSR,
  output logic [XLEN-1:0]          WB_BR_JMP_TARGET,
  output logic                     WB_PC_MUX_OUT,
  output logic                     WB_CS,
  output logic [XLEN-1:0]          WB_CAUSE,
  output logic [XLEN-1:0]          WB_EPC,
  output logic [XLEN-1:0]          WB_TVAL,
  output logic                     WB_FLUSH
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]              WB_INSTRET
`endif
);

  localparam int unsigned OPC_W  = 7;
  localparam int unsigned F3_W   = 3;
  localparam int unsigned CODE_W = XLEN - 1;
  localparam int unsigned CNT_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_OPIMMW = 7'b0011011;
  localparam logic [OPC_W-1:0] OPC_OPW    = 7'b0111011;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_FLUSH
  } state_t;

  typedef enum logic [2:0] {
    WR_NONE,
    WR_MEM,
    WR_ALU,
    WR_NPC,
    WR_CSR
  } wr_sel_t;

  state_t            state;
  logic [CNT_W-1:0]  flush_cnt;

  logic [OPC_W-1:0]  opcode_c;
  logic [F3_W-1:0]   funct3_c;
  wr_sel_t           wr_sel_c;

  logic              irq_any_c;
  logic [CODE_W-1:0] lirq_code_c;
  logic              trap_c;
  logic [XLEN-1:0]   cause_c;
  logic [XLEN-1:0]   tval_c;
  logic              retire_c;

  // Classify the instruction by which result it writes back.
  always_comb begin
    opcode_c = WB_IR[OPC_W-1:0];
    funct3_c = WB_IR[14:12];
    wr_sel_c = WR_NONE;
    case (opcode_c)
      OPC_LOAD:                     wr_sel_c = WR_MEM;
      OPC_OPIMM, OPC_OP, OPC_OPIMMW,
      OPC_OPW, OPC_LUI, OPC_AUIPC:  wr_sel_c = WR_ALU;
      OPC_JAL, OPC_JALR:            wr_sel_c = WR_NPC;
      OPC_SYSTEM: begin
        if (funct3_c != '0) begin
          wr_sel_c = WR_CSR;
        end
      end
      default:                      wr_sel_c = WR_NONE;
    endcase
  end

  // Encode the highest-priority pending trap into mcause/mtval form.
  always_comb begin
    trap_c      = 1'b0;
    cause_c     = '0;
    tval_c      = '0;
    lirq_code_c = '0;
    irq_any_c   = EXTERNAL | TIMER | (|LOCAL_IRQ);

    // Ascending scan so the highest-index pending line wins.
    for (int i = 0; i < int'(NUM_LOCAL_IRQ); i++) begin
      if (LOCAL_IRQ[i]) begin
        lirq_code_c = CODE_W'(16 + i);
      end
    end

    if (GLOBAL_IE && irq_any_c) begin
      trap_c = 1'b1;
      if (EXTERNAL) begin
        cause_c = {1'b1, CODE_W'(11)};
      end else if (TIMER) begin
        cause_c = {1'b1, CODE_W'(7)};
      end else begin
        cause_c = {1'b1, lirq_code_c};
      end
    end else if (FE_IAF) begin
      trap_c  = 1'b1;
      cause_c = XLEN'(1);
      tval_c  = WB_BADADDR;
    end else if (FE_IAM) begin
      trap_c  = 1'b1;
      cause_c = XLEN'(0);
      tval_c  = WB_BADADDR;
    end else if (FE_II) begin
      trap_c  = 1'b1;
      cause_c = XLEN'(2);
      tval_c  = XLEN'(WB_IR);
    end else if (WB_ECALL) begin
      trap_c  = 1'b1;
      cause_c = PRIVILEGE ? XLEN'(11) : XLEN'(8);
    end else if (MEM_SAF) begin
      trap_c  = 1'b1;
      cause_c = XLEN'(7);
      tval_c  = WB_BADADDR;
    end else if (MEM_SAM) begin
      trap_c  = 1'b1;
      cause_c = XLEN'(6);
      tval_c  = WB_BADADDR;
    end else if (MEM_LAF) begin
      trap_c  = 1'b1;
      cause_c = XLEN'(5);
      tval_c  = WB_BADADDR;
    end else if (MEM_LAM) begin
      trap_c  = 1'b1;
      cause_c = XLEN'(4);
      tval_c  = WB_BADADDR;
    end
  end

  // An instruction retires when it is valid, not trapping and not being flushed.
  assign retire_c = WB_V && (state == ST_IDLE) && !trap_c;

  // Trap-sequencing FSM together with the registered writeback outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state            <= ST_IDLE;
      flush_cnt        <= '0;
      WB_RF_DATA       <= '0;
      WB_DRID_OUT      <= '0;
      WB_ST_REG        <= 1'b0;
      WB_CSR_DATA      <= '0;
      WB_ST_CSR        <= 1'b0;
      WB_BR_JMP_TARGET <= '0;
      WB_PC_MUX_OUT    <= 1'b0;
      WB_CS            <= 1'b0;
      WB_CAUSE         <= '0;
      WB_EPC           <= '0;
      WB_TVAL          <= '0;
      WB_FLUSH         <= 1'b0;
    end else begin
      // Enables and pulses last exactly one cycle unless re-asserted below.
      WB_CS         <= 1'b0;
      WB_ST_REG     <= 1'b0;
      WB_ST_CSR     <= 1'b0;
      WB_PC_MUX_OUT <= 1'b0;

      case (state)
        ST_IDLE: begin
          WB_FLUSH <= 1'b0;
          if (WB_V) begin
            if (trap_c) begin
              // Trapping instruction is not retired; only the trap state updates.
              WB_CS     <= 1'b1;
              WB_FLUSH  <= 1'b1;
              WB_CAUSE  <= cause_c;
              WB_EPC    <= WB_PC;
              WB_TVAL   <= tval_c;
              flush_cnt <= CNT_W'(FLUSH_CYCLES - 1);
              state     <= ST_FLUSH;
            end else begin
              WB_DRID_OUT      <= WB_DRID;
              WB_BR_JMP_TARGET <= WB_ALU_RESULT;
              WB_PC_MUX_OUT    <= WB_PC_MUX;
              case (wr_sel_c)
                WR_MEM: begin
                  WB_RF_DATA <= WB_MEM_RESULT;
                  WB_ST_REG  <= (WB_DRID != '0);
                end
                WR_ALU: begin
                  WB_RF_DATA <= WB_ALU_RESULT;
                  WB_ST_REG  <= (WB_DRID != '0);
                end
                WR_NPC: begin
                  WB_RF_DATA <= WB_NPC;
                  WB_ST_REG  <= (WB_DRID != '0);
                end
                WR_CSR: begin
                  WB_RF_DATA  <= WB_RFD;
                  WB_ST_REG   <= (WB_DRID != '0);
                  WB_CSR_DATA <= WB_CSRFD;
                  WB_ST_CSR   <= 1'b1;
                end
                default: begin
                  WB_ST_REG <= 1'b0;
                  WB_ST_CSR <= 1'b0;
                end
              endcase
            end
          end
        end

        ST_FLUSH: begin
          // Inputs are masked; count down the remaining flush cycles.
          if (flush_cnt == '0) begin
            WB_FLUSH <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            WB_FLUSH  <= 1'b1;
            flush_cnt <= flush_cnt - CNT_W'(1);
          end
        end
      endcase
    end
  end

`ifdef WB_RETIRE_CNT_EN
  // Retired-instruction counter, wraps naturally at 2^64.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      WB_INSTRET <= '0;
    end else if (retire_c) begin
      WB_INSTRET <= WB_INSTRET + 64'd1;
    end
  end
`else
  // Retire qualifier only feeds the optional counter.
  logic unused_retire;
  assign unused_retire = retire_c;
`endif

endmodule

// File: tb/tb_writeback_trap.sv
// tb_writeback_trap: directed scoreboard bench for writeback_trap (default parameters).

module tb_writeback_trap;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;
  localparam int unsigned NIRQ = 4;

  logic            CLK = 1'b0;
  logic            RESET;
  logic            WB_V;
  logic [XLEN-1:0] WB_PC, WB_NPC, WB_ALU_RESULT, WB_MEM_RESULT, WB_RFD, WB_CSRFD;
  logic [ILEN-1:0] WB_IR;
  logic [4:0]      WB_DRID;
  logic            WB_PC_MUX;
  logic            WB_ECALL, FE_IAM, FE_IAF, FE_II, MEM_LAM, MEM_LAF, MEM_SAM, MEM_SAF;
  logic [XLEN-1:0] WB_BADADDR;
  logic            TIMER, EXTERNAL;
  logic [NIRQ-1:0] LOCAL_IRQ;
  logic            GLOBAL_IE, PRIVILEGE;
  logic [XLEN-1:0] WB_RF_DATA, WB_CSR_DATA, WB_BR_JMP_TARGET, WB_CAUSE, WB_EPC, WB_TVAL;
  logic [4:0]      WB_DRID_OUT;
  logic            WB_ST_REG, WB_ST_CSR, WB_PC_MUX_OUT, WB_CS, WB_FLUSH;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0]     WB_INSTRET;
`endif

  writeback_trap #(
    .XLEN(XLEN), .ILEN(ILEN), .NUM_LOCAL_IRQ(NIRQ), .FLUSH_CYCLES(3)
  ) dut (
    .CLK(CLK), .RESET(RESET), .WB_V(WB_V), .WB_PC(WB_PC), .WB_NPC(WB_NPC),
    .WB_IR(WB_IR), .WB_ALU_RESULT(WB_ALU_RESULT), .WB_MEM_RESULT(WB_MEM_RESULT),
    .WB_RFD(WB_RFD), .WB_CSRFD(WB_CSRFD), .WB_DRID(WB_DRID), .WB_PC_MUX(WB_PC_MUX),
    .WB_ECALL(WB_ECALL), .FE_IAM(FE_IAM), .FE_IAF(FE_IAF), .FE_II(FE_II),
    .MEM_LAM(MEM_LAM), .MEM_LAF(MEM_LAF), .MEM_SAM(MEM_SAM), .MEM_SAF(MEM_SAF),
    .WB_BADADDR(WB_BADADDR), .TIMER(TIMER), .EXTERNAL(EXTERNAL), .LOCAL_IRQ(LOCAL_IRQ),
    .GLOBAL_IE(GLOBAL_IE), .PRIVILEGE(PRIVILEGE),
    .WB_RF_DATA(WB_RF_DATA), .WB_DRID_OUT(WB_DRID_OUT), .WB_ST_REG(WB_ST_REG),
    .WB_CSR_DATA(WB_CSR_DATA), .WB_ST_CSR(WB_ST_CSR), .WB_BR_JMP_TARGET(WB_BR_JMP_TARGET),
    .WB_PC_MUX_OUT(WB_PC_MUX_OUT), .WB_CS(WB_CS), .WB_CAUSE(WB_CAUSE), .WB_EPC(WB_EPC),
    .WB_TVAL(WB_TVAL), .WB_FLUSH(WB_FLUSH)
`ifdef WB_RETIRE_CNT_EN
    , .WB_INSTRET(WB_INSTRET)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [63:0] rf;
    logic [4:0]  drid;
    logic        st_reg;
    logic [63:0] csr;
    logic        st_csr;
    logic [63:0] tgt;
    logic        pc_mux;
    logic        cs;
    logic [63:0] cause;
    logic [63:0] epc;
    logic [63:0] tval;
    logic        flush;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;

  localparam logic [31:0] IR_ADDI  = 32'h00A00293;
  localparam logic [31:0] IR_LW_X0 = 32'h00002003;
  localparam logic [31:0] IR_LW_X3 = 32'h00002183;
  localparam logic [31:0] IR_JAL   = 32'h004000EF;
  localparam logic [31:0] IR_CSRRW = 32'h34029073;
  localparam logic [31:0] IR_ECALL = 32'h00000073;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Queue the expectation, clock once, then pop and compare against the outputs.
  task automatic step(input string name);
    exp_t x;
    sb_q.push_back(e);
    @(posedge CLK);
    #1;
    x = sb_q.pop_front();
    chk({name, ".rf_data"},  WB_RF_DATA,                x.rf);
    chk({name, ".drid_out"}, 64'(WB_DRID_OUT),          64'(x.drid));
    chk({name, ".st_reg"},   64'(WB_ST_REG),            64'(x.st_reg));
    chk({name, ".csr_data"}, WB_CSR_DATA,               x.csr);
    chk({name, ".st_csr"},   64'(WB_ST_CSR),            64'(x.st_csr));
    chk({name, ".target"},   WB_BR_JMP_TARGET,          x.tgt);
    chk({name, ".pc_mux"},   64'(WB_PC_MUX_OUT),        64'(x.pc_mux));
    chk({name, ".cs"},       64'(WB_CS),                64'(x.cs));
    chk({name, ".cause"},    WB_CAUSE,                  x.cause);
    chk({name, ".epc"},      WB_EPC,                    x.epc);
    chk({name, ".tval"},     WB_TVAL,                   x.tval);
    chk({name, ".flush"},    64'(WB_FLUSH),             64'(x.flush));
  endtask

  task automatic clr_in();
    WB_V = 1'b0; WB_PC_MUX = 1'b0;
    WB_ECALL = 1'b0; FE_IAM = 1'b0; FE_IAF = 1'b0; FE_II = 1'b0;
    MEM_LAM = 1'b0; MEM_LAF = 1'b0; MEM_SAM = 1'b0; MEM_SAF = 1'b0;
    TIMER = 1'b0; EXTERNAL = 1'b0; LOCAL_IRQ = '0; GLOBAL_IE = 1'b0; PRIVILEGE = 1'b0;
  endtask

  task automatic pulse_off();
    e.cs = 1'b0; e.st_reg = 1'b0; e.st_csr = 1'b0; e.pc_mux = 1'b0;
  endtask

  // Three flush cycles after a trap with idle inputs; data outputs hold.
  task automatic flush_tail(input string name);
    clr_in();
    pulse_off();
    e.flush = 1'b1;
    step({name, "_f1"});
    step({name, "_f2"});
    e.flush = 1'b0;
    step({name, "_f3"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    clr_in();
    RESET = 1'b1;
    WB_PC = '0; WB_NPC = '0; WB_ALU_RESULT = 64'h1234; WB_MEM_RESULT = '0;
    WB_RFD = '0; WB_CSRFD = '0; WB_BADADDR = '0;
    WB_IR = IR_ADDI; WB_DRID = 5'd5; WB_V = 1'b1;
    e = '{default: '0};
    step("rst0");
    step("rst1");

    // ADDI x5
    RESET = 1'b0;
    WB_V = 1'b1; WB_IR = IR_ADDI; WB_ALU_RESULT = 64'd10; WB_DRID = 5'd5;
    WB_PC = 64'h100; WB_NPC = 64'h104;
    pulse_off(); e.rf = 64'd10; e.drid = 5'd5; e.st_reg = 1'b1; e.tgt = 64'd10;
    step("addi");

    WB_V = 1'b0;
    pulse_off();
    step("idle0");

    // Load into x0: data selected, write suppressed
    WB_V = 1'b1; WB_IR = IR_LW_X0; WB_MEM_RESULT = 64'hDEAD; WB_ALU_RESULT = 64'h40;
    WB_DRID = 5'd0;
    pulse_off(); e.rf = 64'hDEAD; e.drid = 5'd0; e.tgt = 64'h40;
    step("load_x0");

    // JAL x1 with taken redirect
    WB_IR = IR_JAL; WB_NPC = 64'h1004; WB_PC = 64'h1000; WB_ALU_RESULT = 64'h1010;
    WB_PC_MUX = 1'b1; WB_DRID = 5'd1;
    pulse_off(); e.rf = 64'h1004; e.drid = 5'd1; e.st_reg = 1'b1; e.tgt = 64'h1010;
    e.pc_mux = 1'b1;
    step("jal");

    // CSRRW with rd = x0
    WB_IR = IR_CSRRW; WB_RFD = 64'h11; WB_CSRFD = 64'h22; WB_DRID = 5'd0;
    WB_ALU_RESULT = 64'h77; WB_PC_MUX = 1'b0;
    pulse_off(); e.st_csr = 1'b1; e.csr = 64'h22; e.rf = 64'h11; e.drid = 5'd0;
    e.tgt = 64'h77;
    step("csrrw");

    WB_V = 1'b0;
    pulse_off();
    step("idle1");

    // ECALL from user mode
    WB_V = 1'b1; WB_IR = IR_ECALL; WB_ECALL = 1'b1; PRIVILEGE = 1'b0; WB_PC = 64'h200;
    pulse_off(); e.cs = 1'b1; e.cause = 64'd8; e.epc = 64'h200; e.tval = '0; e.flush = 1'b1;
    step("ecall_u");

    // Valid load during flush must not write, including the last flush cycle
    WB_ECALL = 1'b0; WB_IR = IR_LW_X3; WB_DRID = 5'd3; WB_MEM_RESULT = 64'h55;
    WB_ALU_RESULT = 64'h0;
    pulse_off();
    step("flush_ld1");
    step("flush_ld2");
    e.flush = 1'b0;
    step("flush_ld3");
    e.rf = 64'h55; e.drid = 5'd3; e.st_reg = 1'b1; e.tgt = 64'h0;
    step("load_x3");

    // IAF beats LAM
    WB_V = 1'b1; FE_IAF = 1'b1; MEM_LAM = 1'b1; WB_BADADDR = 64'h3; WB_PC = 64'h300;
    pulse_off(); e.cs = 1'b1; e.cause = 64'd1; e.epc = 64'h300; e.tval = 64'h3; e.flush = 1'b1;
    step("iaf_lam");
    flush_tail("iaf");

    // Illegal instruction: tval is the zero-extended instruction
    WB_V = 1'b1; FE_II = 1'b1; WB_IR = 32'hFFFFFFFF; WB_PC = 64'h400; WB_BADADDR = 64'h123;
    pulse_off(); e.cs = 1'b1; e.cause = 64'd2; e.epc = 64'h400; e.tval = 64'h00000000FFFFFFFF;
    e.flush = 1'b1;
    step("ii");
    flush_tail("ii");

    // IAM beats II
    WB_V = 1'b1; FE_IAM = 1'b1; FE_II = 1'b1; WB_BADADDR = 64'h402; WB_PC = 64'h404;
    pulse_off(); e.cs = 1'b1; e.cause = 64'd0; e.epc = 64'h404; e.tval = 64'h402; e.flush = 1'b1;
    step("iam_ii");
    flush_tail("iam");

    // SAM beats LAF
    WB_V = 1'b1; WB_IR = IR_LW_X3; MEM_SAM = 1'b1; MEM_LAF = 1'b1; WB_BADADDR = 64'hAB;
    WB_PC = 64'h800;
    pulse_off(); e.cs = 1'b1; e.cause = 64'd6; e.epc = 64'h800; e.tval = 64'hAB; e.flush = 1'b1;
    step("sam_laf");
    flush_tail("sam");

    // Pending interrupt with no valid instruction is ignored
    EXTERNAL = 1'b1; GLOBAL_IE = 1'b1; WB_V = 1'b0;
    pulse_off();
    step("irq_nov");

    // External beats timer and a store fault; tval is zero
    WB_V = 1'b1; WB_IR = IR_ADDI; TIMER = 1'b1; MEM_SAF = 1'b1; WB_BADADDR = 64'h99;
    WB_PC = 64'h500;
    pulse_off(); e.cs = 1'b1; e.cause = 64'h800000000000000B; e.epc = 64'h500; e.tval = '0;
    e.flush = 1'b1;
    step("irq_ext");
    flush_tail("ext");

    // Highest-index local interrupt wins
    WB_V = 1'b1; GLOBAL_IE = 1'b1; LOCAL_IRQ = 4'b0101; WB_PC = 64'h600;
    pulse_off(); e.cs = 1'b1; e.cause = 64'h8000000000000012; e.epc = 64'h600; e.tval = '0;
    e.flush = 1'b1;
    step("irq_local");
    flush_tail("local");

    // Timer beats local interrupts
    WB_V = 1'b1; GLOBAL_IE = 1'b1; TIMER = 1'b1; LOCAL_IRQ = 4'b1000; WB_PC = 64'h640;
    pulse_off(); e.cs = 1'b1; e.cause = 64'h8000000000000007; e.epc = 64'h640; e.tval = '0;
    e.flush = 1'b1;
    step("irq_timer");
    flush_tail("timer");

    // Interrupts disabled: normal writeback, trap state holds
    WB_V = 1'b1; EXTERNAL = 1'b1; TIMER = 1'b1; GLOBAL_IE = 1'b0;
    WB_IR = IR_ADDI; WB_ALU_RESULT = 64'h33; WB_DRID = 5'd5; WB_PC_MUX = 1'b0;
    pulse_off(); e.rf = 64'h33; e.drid = 5'd5; e.st_reg = 1'b1; e.tgt = 64'h33;
    step("gie_off");

    // ECALL from machine mode beats SAM
    clr_in();
    WB_V = 1'b1; WB_IR = IR_ECALL; WB_ECALL = 1'b1; PRIVILEGE = 1'b1; MEM_SAM = 1'b1;
    WB_BADADDR = 64'h88; WB_PC = 64'h700;
    pulse_off(); e.cs = 1'b1; e.cause = 64'd11; e.epc = 64'h700; e.tval = '0; e.flush = 1'b1;
    step("ecall_m");

    // Reset in the middle of the flush
    clr_in();
    RESET = 1'b1;
    e = '{default: '0};
    step("rst_mid");
    RESET = 1'b0;
    step("post_rst");

    // Back to normal operation straight after reset
    WB_V = 1'b1; WB_IR = IR_ADDI; WB_ALU_RESULT = 64'h44; WB_DRID = 5'd5;
    pulse_off(); e.rf = 64'h44; e.drid = 5'd5; e.st_reg = 1'b1; e.tgt = 64'h44;
    step("addi_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
